// File: rtl/symbol_word_packer.sv
// Packs SYM_W-bit symbols MSB-first into SYMS_PER_WORD-symbol words over valid/ready streams.
// Optional PACKER_WORD_CNT_EN adds a saturating 32-bit count of delivered words (word_cnt).
module symbol_word_packer #(
   parameter int SYM_W = 8,
   parameter int SYMS_PER_WORD = 4,
   localparam int WORD_W = SYM_W * SYMS_PER_WORD,
   localparam int CNT_W = $clog2(SYMS_PER_WORD + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s_valid,
   output logic              s_ready,
   input  logic [SYM_W-1:0]  s_sym,
   input  logic              s_last,
   input  logic              flush,
   output logic              m_valid,
   input  logic              m_ready,
   output logic [WORD_W-1:0] m_word,
   output logic [CNT_W-1:0]  m_count,
   output logic              m_last
`ifdef PACKER_WORD_CNT_EN
   ,
   output logic [31:0]       word_cnt
`endif
);

   logic [WORD_W-1:0] acc_p0;
   logic [CNT_W-1:0]  cnt_p0;
   logic [WORD_W-1:0] acc_ins;
   logic [WORD_W-1:0] sym_msb;
   logic [CNT_W-1:0]  cnt_inc;
   logic              accept;
   logic              last_eff;
   logic              close_sym;
   logic              close_flush;

   assign s_ready = !m_valid || m_ready;
   assign accept  = s_valid && s_ready;
   // A flush arriving together with a symbol behaves as s_last on that symbol.
   assign last_eff = s_last || flush;

   always_comb begin
      sym_msb     = {s_sym, {(WORD_W - SYM_W){1'b0}}};
      acc_ins     = acc_p0 | (sym_msb >> (SYM_W * int'(cnt_p0)));
      cnt_inc     = cnt_p0 + CNT_W'(1);
      close_sym   = accept && ((cnt_inc == CNT_W'(SYMS_PER_WORD)) || last_eff);
      close_flush = !accept && flush && (cnt_p0 != '0) && s_ready;
   end

   // Stage p0 -> output holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_p0  <= '0;
         cnt_p0  <= '0;
         m_valid <= 1'b0;
         m_word  <= '0;
         m_count <= '0;
         m_last  <= 1'b0;
      end else if (close_sym) begin
         m_word  <= acc_ins;
         m_count <= cnt_inc;
         m_last  <= last_eff;
         m_valid <= 1'b1;
         acc_p0  <= '0;
         cnt_p0  <= '0;
      end else if (close_flush) begin
         m_word  <= acc_p0;
         m_count <= cnt_p0;
         m_last  <= 1'b1;
         m_valid <= 1'b1;
         acc_p0  <= '0;
         cnt_p0  <= '0;
      end else begin
         if (m_valid && m_ready) m_valid <= 1'b0;
         if (accept) begin
            acc_p0 <= acc_ins;
            cnt_p0 <= cnt_inc;
         end
      end
   end

`ifdef PACKER_WORD_CNT_EN
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) word_cnt <= '0;
      else if (m_valid && m_ready) word_cnt <= sat_inc32(word_cnt);
   end
`endif

endmodule

// File: tb/tb_symbol_word_packer.sv
// Scoreboard bench for symbol_word_packer (default parameters); checks word_cnt when PACKER_WORD_CNT_EN is set.
`timescale 1ns/1ps
module tb_symbol_word_packer;

   typedef struct packed {
      logic [31:0] word;
      logic [2:0]  count;
      logic        last;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [7:0]  s_sym = '0;
   logic        s_last = 1'b0;
   logic        flush = 1'b0;
   logic        m_valid;
   logic        m_ready = 1'b1;
   logic [31:0] m_word;
   logic [2:0]  m_count;
   logic        m_last;
`ifdef PACKER_WORD_CNT_EN
   logic [31:0] word_cnt;
   int          hs_since_rst = 0;
`endif

   exp_t q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   symbol_word_packer dut (
      .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_sym(s_sym),
      .s_last(s_last), .flush(flush), .m_valid(m_valid), .m_ready(m_ready),
      .m_word(m_word), .m_count(m_count), .m_last(m_last)
`ifdef PACKER_WORD_CNT_EN
      , .word_cnt(word_cnt)
`endif
   );

   // Output monitor: every delivered word is popped from the scoreboard and compared.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && m_valid && m_ready) begin
`ifdef PACKER_WORD_CNT_EN
         hs_since_rst++;
`endif
         n_cmp++;
         if (q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_word: got %h count %0d last %0d, required none", m_word, m_count, m_last);
         end else begin
            e = q.pop_front();
            if (m_word !== e.word) begin
               n_fail++;
               $display("FAIL word: got %h required %h", m_word, e.word);
            end
            n_cmp++;
            if (m_count !== e.count) begin
               n_fail++;
               $display("FAIL count: got %0d required %0d (word %h)", m_count, e.count, e.word);
            end
            n_cmp++;
            if (m_last !== e.last) begin
               n_fail++;
               $display("FAIL last: got %0d required %0d (word %h)", m_last, e.last, e.word);
            end
         end
      end
`ifdef PACKER_WORD_CNT_EN
      else if (rst) hs_since_rst = 0;
`endif
   end

   // Drive one symbol; returns at posedge+1 after it was accepted.
   task automatic send(input logic [7:0] sym, input logic last);
      bit ok = 0;
      s_valid = 1'b1; s_sym = sym; s_last = last;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (s_ready) begin ok = 1; break; end
      end
      if (!ok) begin
         n_cmp++; n_fail++;
         $display("FAIL send_timeout: symbol %h not accepted within 100 clks, required acceptance", sym);
      end
      @(posedge clk); #1;
      s_valid = 1'b0; s_last = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      idle(2);
      n_cmp++;
      if ({m_valid, m_word, m_count, m_last} !== 37'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got v%0d w%h c%0d l%0d, required all 0", m_valid, m_word, m_count, m_last);
      end
      n_cmp++;
      if (s_ready !== 1'b1) begin
         n_fail++; $display("FAIL reset_s_ready: got %0d required 1", s_ready);
      end
      rst = 1'b0;
      idle(1);
   endtask

   task automatic test_full_word;
      m_ready = 1'b1;
      q.push_back('{32'hF0FF0FF0, 3'd4, 1'b0});
      send(8'hF0, 0); send(8'hFF, 0); send(8'h0F, 0);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_fail++; $display("FAIL early_valid: got %0d required 0 before 4th symbol", m_valid);
      end
      send(8'hF0, 0);
      n_cmp++;
      if (m_valid !== 1'b1 || m_word !== 32'hF0FF0FF0) begin
         n_fail++; $display("FAIL latency: got v%0d w%h required v1 wF0FF0FF0", m_valid, m_word);
      end
      idle(1);
      n_cmp++;
      if (m_valid !== 1'b0) begin
         n_fail++; $display("FAIL drain: got m_valid %0d required 0", m_valid);
      end
   endtask

   task automatic test_last;
      q.push_back('{32'hAABB0000, 3'd2, 1'b1});
      q.push_back('{32'h11223344, 3'd4, 1'b0});
      send(8'hAA, 0); send(8'hBB, 1);
      send(8'h11, 0); send(8'h22, 0); send(8'h33, 0); send(8'h44, 0);
      idle(2);
   endtask

   task automatic test_flush;
      q.push_back('{32'h01020300, 3'd3, 1'b1});
      send(8'h01, 0); send(8'h02, 0); send(8'h03, 0);
      flush = 1'b1; idle(1); flush = 1'b0;
      n_cmp++;
      if (m_valid !== 1'b1 || m_count !== 3'd3) begin
         n_fail++; $display("FAIL flush_close: got v%0d c%0d required v1 c3", m_valid, m_count);
      end
      idle(2);
      flush = 1'b1; idle(1); flush = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         n_cmp++;
         if (m_valid !== 1'b0) begin
            n_fail++; $display("FAIL empty_flush: got m_valid %0d required 0", m_valid);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_backpressure;
      bit done = 0;
      m_ready = 1'b0;
      q.push_back('{32'h00010203, 3'd4, 1'b0});
      q.push_back('{32'h04050607, 3'd4, 1'b0});
      q.push_back('{32'h08090A0B, 3'd4, 1'b0});
      for (int s = 0; s < 4; s++) send(8'(s), 0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         n_cmp++;
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_word !== 32'h00010203 ||
             m_count !== 3'd4 || m_last !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_stable: got r%0d v%0d w%h c%0d l%0d required r0 v1 w00010203 c4 l0",
                     s_ready, m_valid, m_word, m_count, m_last);
         end
      end
      @(posedge clk); #1;
      m_ready = 1'b1;
      fork
         begin
            for (int s = 4; s < 12; s++) send(8'(s), 0);
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk); #1;
               if (!done) m_ready = ($urandom_range(0, 2) != 0);
            end
         end
      join
      m_ready = 1'b1;
      idle(3);
   endtask

   task automatic test_back_to_back;
      int stalls = 0;
      int slots[$];
      for (int w = 0; w < 4; w++)
         q.push_back('{{8'(4*w+8'h20), 8'(4*w+8'h21), 8'(4*w+8'h22), 8'(4*w+8'h23)}, 3'd4, 1'b0});
      m_ready = 1'b1;
      fork
         for (int s = 0; s < 16; s++) send(8'(s + 8'h20), 0);
         for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (s_valid && !s_ready) stalls++;
            if (m_valid) slots.push_back(c);
         end
      join
      n_cmp++;
      if (stalls != 0) begin
         n_fail++; $display("FAIL b2b_stalls: got %0d stall cycles required 0", stalls);
      end
      n_cmp++;
      if (slots.size() != 4) begin
         n_fail++; $display("FAIL b2b_words: got %0d valid cycles required 4", slots.size());
      end else begin
         for (int i = 1; i < 4; i++) begin
            n_cmp++;
            if (slots[i] - slots[i-1] != 4) begin
               n_fail++; $display("FAIL b2b_spacing: got %0d clks required 4", slots[i] - slots[i-1]);
            end
         end
      end
      idle(2);
   endtask

   task automatic test_reset_mid;
      send(8'h55, 0); send(8'h66, 0);
      rst = 1'b1; idle(1); rst = 1'b0;
      n_cmp++;
      if ({m_valid, m_word, m_count, m_last} !== 37'd0) begin
         n_fail++;
         $display("FAIL mid_reset: got v%0d w%h c%0d l%0d required all 0", m_valid, m_word, m_count, m_last);
      end
`ifdef PACKER_WORD_CNT_EN
      n_cmp++;
      if (word_cnt !== 32'd0) begin
         n_fail++; $display("FAIL word_cnt_reset: got %0d required 0", word_cnt);
      end
`endif
      idle(2);
      q.push_back('{32'hC1C2C3C4, 3'd4, 1'b0});
      send(8'hC1, 0); send(8'hC2, 0); send(8'hC3, 0); send(8'hC4, 0);
      idle(2);
`ifdef PACKER_WORD_CNT_EN
      n_cmp++;
      if (word_cnt !== 32'(hs_since_rst)) begin
         n_fail++; $display("FAIL word_cnt: got %0d required %0d", word_cnt, hs_since_rst);
      end
`endif
   endtask

   initial begin
      #1;
      test_reset();
      test_full_word();
      test_last();
      test_flush();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      for (int i = 0; i < 50 && q.size() != 0; i++) idle(1);
      n_cmp++;
      if (q.size() != 0) begin
         n_fail++; $display("FAIL scoreboard_empty: got %0d words outstanding required 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/symbol_word_packer.md
Name: symbol_word_packer

Overview:
Sequential, parametrised successor to the combinational byte-to-word merger on the decompression path. It accepts decoded SYM_W-bit symbols one per cycle over a valid/ready stream and packs SYMS_PER_WORD of them MSB-first into one output word. It supports partial-word flush at end of stream and downstream backpressure. It sits between the Huffman decoder output and the bitstream word writer.

Parameters:
SYM_W, 8, width of one input symbol in bits (>=1)
SYMS_PER_WORD, 4, symbols per output word (>=2)
WORD_W, SYM_W*SYMS_PER_WORD, output word width; derived, must not be overridden
CNT_W, $clog2(SYMS_PER_WORD+1), width of the symbol-count fields; derived

Ports:
clk  in  1  single clock; all logic on rising edge
rst  in  1  reset; synchronous, active-high
s_valid  in  1  input symbol valid
s_ready  out  1  packer can accept a symbol this cycle
s_sym  in  SYM_W  input symbol
s_last  in  1  symbol is last of stream; close the word after it
flush  in  1  close the current partial word without a new symbol
m_valid  out  1  output word valid
m_ready  in  1  downstream accepts the word
m_word  out  WORD_W  packed word; first-received symbol in the MSBs
m_count  out  CNT_W  number of valid symbols in m_word (1..SYMS_PER_WORD)
m_last  out  1  word closed by s_last or flush

Behaviour:
- Reset values: m_valid=0, m_word=0, m_count=0, m_last=0. Accumulator is cleared and its count cnt is 0.
- Storage is an accumulator (cnt symbols, 0..SYMS_PER_WORD-1) plus one output holding register.
- The input accepts a symbol when s_valid && s_ready.
- s_ready = !m_valid || m_ready. This is a combinational path from m_ready and has no dependence on s_valid or s_last.
- Accepted symbol at index cnt goes to accumulator bits [WORD_W-1-cnt*SYM_W -: SYM_W].
- Closing condition: the accepted symbol makes cnt+1==SYMS_PER_WORD, or s_last=1 on it. On the next edge:
  - The holding register loads the accumulator including the new symbol.
  - m_count=cnt+1, m_last=s_last, m_valid=1.
  - cnt returns to 0 and the accumulator clears to 0.
- Partial words are left-justified; unused LSBs are zero.
- flush with no accept, cnt>0, and the holding register free (s_ready=1): close the partial word with m_count=cnt and m_last=1.
- flush with cnt==0: no effect and no empty word.
- flush with an accept in the same cycle: treated as s_last=1 on that symbol.
- flush while s_ready=0: ignored. The requester must hold flush until s_ready=1.
- Output handshake:
  - m_valid, m_word, m_count and m_last stay stable while m_valid && !m_ready.
  - On m_valid && m_ready with no new closing event, m_valid goes to 0 next cycle.
  - On drain and close in the same cycle, the holding register reloads and m_valid stays 1. Sustained throughput is 1 symbol/clk.
- Latency: 1 clk from the closing symbol being accepted to m_valid=1.
- cnt never reaches SYMS_PER_WORD, so there is no overflow.
- rst mid-word or mid-hold discards the accumulator and any pending word, with no output.
- All reset behaviour is synchronous.

Optional Feature:
Macro PACKER_WORD_CNT_EN.
- Defined: adds output port word_cnt, out, 32 bits. It is reset to 0 by rst, increments by 1 on each m_valid && m_ready, and saturates at 32'hFFFFFFFF.
- Undefined: the port and its counter do not exist. All other behaviour is identical.

Test Plan:
- Defaults; symbols F0,FF,0F,F0 on consecutive clks with m_ready=1 -> one word m_word=F0FF0FF0, m_count=4, m_last=0, valid 1 clk after the 4th accept.
- Symbols AA,BB with s_last on BB -> m_word=AABB0000, m_count=2, m_last=1. Next symbol 11 lands at MSBs of the next word.
- cnt=3 (01,02,03) then flush with s_valid=0 -> 01020300, m_count=3, m_last=1. flush at cnt=0 -> m_valid stays 0.
- m_ready=0 with a word pending -> s_ready=0 and outputs stable for 5 clks. m_ready=1 -> word drains. A 12-symbol stream 00..0B gives 00010203, 04050607, 08090A0B in order with none lost.
- Continuous 16 symbols with m_ready=1 -> s_ready never drops and 4 words arrive on 4 consecutive-per-4 clk slots.
- rst for 1 clk after 2 symbols accepted -> no word emitted, all outputs 0. The next 4 symbols form a clean word. With PACKER_WORD_CNT_EN, word_cnt returns to 0.
